sr: RTL and testbench

Status register (SR) of the APCPU datapath: an 8-bit clocked register holding the processor flag byte. Each rising clock edge captures the full flag vector presented on `SRSet`, and the stored value is driven on `SRData` to the control unit and the datapath consumers. Because the output is registered, a value written in one cycle is readable only from the next cycle.

---
 rtl/sr.sv | 29 ++
 tb/tb_sr.sv | 133 +++++++++++++
 2 files changed

// File: rtl/sr.sv
// APCPU status register: holds the processor flag byte (C, Z, N, V, reserved 7:4).
// Every rising clock edge loads SRSet in full. SRData is driven straight from the flop.
module sr #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] SRSet,
  output logic [WIDTH-1:0] SRData
);

  logic [WIDTH-1:0] flags_q;
  logic [WIDTH-1:0] flags_d;

  // No enable: the control unit presents the next flags every cycle and reads the old ones.
  assign flags_d = SRSet;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags_q <= RESET_VALUE;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign SRData = flags_q;

endmodule

// File: tb/tb_sr.sv
// Directed bench for the status register: reset behaviour, one-cycle capture latency,
// mid-cycle glitch immunity, asynchronous reset assertion and full-width integrity.
module tb_sr;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] SRSet;
  logic [W-1:0] SRData;

  int n_vec;
  int n_err;

  sr #(.WIDTH(W), .RESET_VALUE(8'h00)) dut (
    .clk    (clk),
    .rst    (rst),
    .SRSet  (SRSet),
    .SRData (SRData)
  );

  // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  logic [W-1:0] prev;
  logic [W-1:0] pat [4];

  initial begin
    n_vec = 0;
    n_err = 0;

    // Reset held low with all-ones input.
    rst   = 1'b0;
    SRSet = 8'hFF;
    #1;
    check("rst_initial", SRData, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_hold_pos", SRData, 8'h00);
      @(negedge clk);
      check("rst_hold_neg", SRData, 8'h00);
    end

    // Release between edges; nothing changes until the next rising edge.
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    check("release_no_edge", SRData, 8'h00);
    @(negedge clk);
    check("release_before_edge", SRData, 8'h00);
    @(posedge clk); #1;
    check("release_first_load", SRData, 8'hFF);
    prev = 8'hFF;

    // Counting sequence: old value before the edge, new value after it.
    for (int i = 0; i <= 8; i++) begin
      SRSet = W'(i);
      @(negedge clk);
      check("count_before", SRData, prev);
      @(posedge clk); #1;
      check("count_after", SRData, W'(i));
      prev = W'(i);
    end

    // Mid-cycle glitch on SRSet must never reach SRData.
    SRSet = 8'h05;
    @(posedge clk); #1;
    check("glitch_load", SRData, 8'h05);
    #1 SRSet = 8'hA0;
    #2;
    check("glitch_mid", SRData, 8'h05);
    #1 SRSet = 8'h05;
    #1;
    check("glitch_restored", SRData, 8'h05);
    @(posedge clk); #1;
    check("glitch_capture", SRData, 8'h05);

    // Asynchronous reset midway between edges.
    SRSet = 8'h3C;
    @(posedge clk); #1;
    check("async_load", SRData, 8'h3C);
    #3;
    rst   = 1'b0;
    SRSet = 8'h77;
    #0.5;
    check("async_immediate", SRData, 8'h00);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("async_hold_pos", SRData, 8'h00);
      @(negedge clk);
      check("async_hold_neg", SRData, 8'h00);
    end

    // Release-then-load with 8'h81 presented.
    SRSet = 8'h81;
    rst   = 1'b1;
    #1;
    check("rel81_before_edge", SRData, 8'h00);
    @(posedge clk); #1;
    check("rel81_load", SRData, 8'h81);

    // Full-width integrity, including reserved bits 7:4.
    pat[0] = 8'hFF;
    pat[1] = 8'h00;
    pat[2] = 8'hAA;
    pat[3] = 8'h55;
    prev   = 8'h81;
    for (int i = 0; i < 4; i++) begin
      SRSet = pat[i];
      @(negedge clk);
      check("bits_before", SRData, prev);
      @(posedge clk); #1;
      check("bits_after", SRData, pat[i]);
      check("bits_reserved", {4'h0, SRData[7:4]}, {4'h0, pat[i][7:4]});
      prev = pat[i];
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
